// File: rtl/aes_sched_pkg.sv
// +----------------------------------------------------------------------+
// | aes_sched_pkg : shared types and constants for aes_dec_sched          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package aes_sched_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int KEY_WAIT_DEF = 12;
  localparam int TIMEOUT_DEF  = 64;
  // Wide enough for both KEY_WAIT-1 (<=254) and TIMEOUT-1 (<=1022).
  localparam int CNT_W        = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLOAD = 3'd1,
    S_KWAIT = 3'd2,
    S_LOAD  = 3'd3,
    S_BUSY  = 3'd4,
    S_RESP  = 3'd5
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_rr_arb2.sv
// +----------------------------------------------------------------------+
// | aes_rr_arb2 : two-way round-robin grant, purely combinational         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module aes_rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // last_i=1 means requester 1 was served most recently, so 0 wins a tie.
  always_comb begin
    gnt0_o = valid0_i & (~valid1_i | last_i);
    gnt1_o = valid1_i & (~valid0_i | ~last_i);
  end

endmodule

`default_nettype wire

// File: rtl/aes_dec_sched.sv
// +----------------------------------------------------------------------+
// | aes_dec_sched : two-port scheduler with key cache for one AES decrypt |
// | core. Rev 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module aes_dec_sched
  import aes_sched_pkg::*;
#(
  parameter int KEY_WAIT = KEY_WAIT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic [AES_BLK_W-1:0] req1_key,
  input  logic [AES_BLK_W-1:0] req0_data,
  input  logic [AES_BLK_W-1:0] req1_data,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  input  logic                 rsp0_ready,
  input  logic                 rsp1_ready,
  output logic [AES_BLK_W-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 aes_kld,
  output logic                 aes_ld,
  output logic [AES_BLK_W-1:0] aes_key,
  output logic [AES_BLK_W-1:0] aes_text_in,
  input  logic                 aes_done,
  input  logic [AES_BLK_W-1:0] aes_text_out
);

  localparam logic [CNT_W-1:0] KW_LOAD = CNT_W'(KEY_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] key_q, key_d;
  logic                 key_vld_q, key_vld_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [AES_BLK_W-1:0] aes_key_q, aes_key_d;
  logic [AES_BLK_W-1:0] text_q, text_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 kld_q, ld_q, rsp0_vld_q, rsp1_vld_q;

  logic                 gnt0, gnt1, idle, accept;
  logic [AES_BLK_W-1:0] key_sel, data_sel;

  aes_rr_arb2 u_arb (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  assign idle       = rst && (state_q == S_IDLE);
  assign accept     = idle && (gnt0 || gnt1);
  assign req0_ready = idle && gnt0;
  assign req1_ready = idle && gnt1;
  assign key_sel    = gnt1 ? req1_key  : req0_key;
  assign data_sel   = gnt1 ? req1_data : req0_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    key_vld_d  = key_vld_q;
    last_d     = last_q;
    owner_d    = owner_q;
    aes_key_d  = aes_key_q;
    text_d     = text_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d   = gnt1;
          aes_key_d = key_sel;
          text_d    = data_sel;
          state_d   = (key_vld_q && (key_sel == key_q)) ? S_LOAD : S_KLOAD;
        end
      end
      S_KLOAD: begin
        key_d     = aes_key_q;
        key_vld_d = 1'b1;
        cnt_d     = KW_LOAD;
        state_d   = S_KWAIT;
      end
      S_KWAIT: begin
        if (cnt_q == '0) state_d = S_LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (aes_done) begin
          rsp_data_d = aes_text_out;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          // A hung core may hold a corrupt schedule: force a reload next time.
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          key_vld_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) key_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      key_vld_q  <= 1'b0;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      aes_key_q  <= '0;
      text_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      kld_q      <= 1'b0;
      ld_q       <= 1'b0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      key_vld_q  <= key_vld_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      aes_key_q  <= aes_key_d;
      text_q     <= text_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      kld_q      <= (state_d == S_KLOAD);
      ld_q       <= (state_d == S_LOAD);
      rsp0_vld_q <= (state_d == S_RESP) && !owner_d;
      rsp1_vld_q <= (state_d == S_RESP) &&  owner_d;
    end
  end

  assign aes_kld     = kld_q;
  assign aes_ld      = ld_q;
  assign aes_key     = aes_key_q;
  assign aes_text_in = text_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp0_valid  = rsp0_vld_q;
  assign rsp1_valid  = rsp1_vld_q;

endmodule

`default_nettype wire

// File: doc/aes_dec_sched.md
# aes_dec_sched

Two-requester scheduler for one shared `aes_inv_cipher_top` decrypt core. It arbitrates round-robin between two valid/ready request ports and caches the last loaded key, so `kld` plus the key-expansion wait is skipped when the key repeats. It sequences the core's `kld`/`ld`/`done` handshake, guards it with a timeout watchdog, and returns plaintext on the winner's response port. It sits between the system bus adapters and the decrypt core.

## Interface
- `KEY_WAIT`, default 12: cycles held in KWAIT after the `kld` pulse before `ld`. Range 1..255.
- `TIMEOUT`, default 64: cycles allowed in BUSY before abort. Range 2..1023.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  one-cycle pulse; clears the key cache (key_vld=0).
- `req0_valid`/`req1_valid`  in  1  request present.
- `req0_ready`/`req1_ready`  out  1  request accepted this cycle.
- `req0_key`/`req1_key`  in  128  decrypt key.
- `req0_data`/`req1_data`  in  128  ciphertext.
- `rsp0_valid`/`rsp1_valid`  out  1  response present.
- `rsp0_ready`/`rsp1_ready`  in  1  response consumed.
- `rsp_data`  out  128  plaintext, shared by both response ports.
- `rsp_err`  out  1  response is a timeout abort; `rsp_data` is 0.
- `aes_kld`  out  1  to core `kld`.
- `aes_ld`  out  1  to core `ld`.
- `aes_key`  out  128  to core `key`.
- `aes_text_in`  out  128  to core `text_in`.
- `aes_done`  in  1  from core `done`.
- `aes_text_out`  in  128  from core `text_out`.

## Operation
- States: IDLE, KLOAD, KWAIT, LOAD, BUSY, RESP.
- **IDLE: grant.**
  - Only requester valid: grant it.
  - Both valid: grant the requester not served last (`last` flag; reset `last`=1, so requester 0 wins first).
  - `reqN_ready` = (state==IDLE) && granted N; combinational from valid and `last`.
  - On accept: latch key/data into `aes_key`/`aes_text_in`, latch `owner`.
  - key_vld && key==key_q: go to LOAD. Otherwise go to KLOAD.
- **KLOAD:** `aes_kld`=1 for exactly one cycle. key_q←key, key_vld←1. Go to KWAIT and load the counter with KEY_WAIT-1.
- **KWAIT:** count down. At 0, go to LOAD.
- **LOAD:** `aes_ld`=1 for exactly one cycle. Go to BUSY and clear the timeout counter.
- **BUSY:**
  - `aes_done`=1: capture `aes_text_out` into `rsp_data`, `rsp_err`=0, go to RESP.
  - Counter reaches TIMEOUT-1 without `done`: `rsp_data`=0, `rsp_err`=1, key_vld←0, go to RESP.
  - `aes_done` outside BUSY is ignored.
- **RESP:**
  - `rsp<owner>_valid`=1; the other response port stays 0.
  - `rsp_data`/`rsp_err` are held stable until `rsp<owner>_ready`.
  - On `rsp<owner>_ready`: `last`←owner, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- **Ownership and stability:**
  - `aes_key`/`aes_text_in` are held from accept until the next accept.
  - `req_ready` is 0 in every non-IDLE state; requests stay pending.
- **flush:**
  - Any state: key_vld←0 next cycle.
  - An in-flight operation completes normally.
  - flush in the same cycle as KLOAD: flush wins (key_vld=0).
- **Reset (rst=0), including mid-operation:**
  - state=IDLE, key_vld=0, key_q=0, `last`=1, counters=0.
  - All outputs 0: `aes_kld`, `aes_ld`, `aes_key`, `aes_text_in`, all ready/valid, `rsp_data`, `rsp_err`.
  - Any in-flight result is discarded.
  - The core is reset independently. The scheduler requires its reset to be asserted together with the core's.

## Timing
- Accept at cycle 0, key hit: `aes_ld` at cycle 1, BUSY from cycle 2.
- Core asserts `done` at cycle D: `rspN_valid` at D+1.
- Key miss: `aes_kld` at cycle 1, KWAIT cycles 2..KEY_WAIT+1, `aes_ld` at cycle KEY_WAIT+2.
- Timeout: `rsp_err` response TIMEOUT+1 cycles after the LOAD cycle.
- Back-to-back requests: earliest next accept is 1 cycle after the response handshake. Minimum issue interval is 3 cycles plus core latency.
- All outputs except `reqN_ready` are registered.

## Structure
- Package `aes_sched_pkg`:
  - state enum, `AES_BLK_W`=128;
  - default constants for KEY_WAIT/TIMEOUT.
- Optional sub-module `aes_rr_arb2`: 2-way round-robin grant from valid and `last`; combinational.
- The key cache comparator (128-bit equality) stays inline.

## Test plan
- **Single key miss:** after reset, req0 key=0, data=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - One `aes_kld` pulse, `aes_ld` exactly KEY_WAIT+1 cycles after `aes_kld`.
  - `rsp0_valid` with `rsp_data`=0, `rsp_err`=0.
- **Key hit:** req1 key=0, data=f795bd4a52e29ed713d313fa20e98dbc.
  - No `aes_kld`; `aes_ld` 1 cycle after accept.
  - `rsp1` data=66e94bd4ef8a2c3b884cfa59ca342b2e.
- **Contention:** both valid continuously for 4 requests.
  - Grants alternate 0,1,0,1.
  - Each response lands only on its owner's port.
- **Backpressure:** hold `rsp0_ready`=0 for 20 cycles.
  - `rsp0_valid`/`rsp_data` stable; `req1_ready` stays 0 until release.
- **Timeout:** core model never asserts `done`.
  - `rsp_err`=1, `rsp_data`=0 after TIMEOUT+1 cycles.
  - Next request with the same key issues `aes_kld`.
- **Reset/flush:**
  - rst=0 during KWAIT: all outputs 0 the next cycle; the subsequent request reloads the key.
  - flush then same-key request: `aes_kld` reissued.
